// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Prediction is combinational from fetch_pc; training comes from the execute stage.
// Optional performance counters are built when the macro BP_PERF_CNT_EN is defined.
module branch_predictor_btb #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              flush_all,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_pred_taken
`ifdef BP_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  perf_branches,
   output logic [CNT_W-1:0]  perf_mispredicts
`endif
);

   localparam int unsigned IDX_W  = $clog2(ENTRIES);
   localparam int unsigned TAG_LO = IDX_W + 2;
   localparam int unsigned TAG_HI = IDX_W + 2 + TAG_W - 1;
   localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

   // Entry array: valid bit, partial tag, full target, direction counter
   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [XLEN-1:0]   target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  fetch_idx_s;
   logic [TAG_W-1:0]  fetch_tag_s;
   logic              fetch_hit_s;
   logic              pred_taken_s;
   logic [IDX_W-1:0]  upd_idx_s;
   logic [TAG_W-1:0]  upd_tag_s;
   logic              upd_hit_s;
   logic              entry_we_s;
   logic [1:0]        ctr_d;
   logic [XLEN-1:0]   target_d;

   assign fetch_idx_s = fetch_pc[IDX_W+1:2];
   assign fetch_tag_s = fetch_pc[TAG_HI:TAG_LO];
   assign upd_idx_s   = upd_pc[IDX_W+1:2];
   assign upd_tag_s   = upd_pc[TAG_HI:TAG_LO];

   // Fetch-side lookup; a miss or weak/strong not-taken falls through to pc+4
   always_comb begin
      fetch_hit_s  = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
      pred_taken_s = fetch_hit_s && ctr_q[fetch_idx_s][1];
      if (pred_taken_s) begin
         pred_target = target_q[fetch_idx_s];
      end else begin
         pred_target = fetch_pc + PC_INC;
      end
      pred_taken = pred_taken_s;
   end

   // Compute the single-entry write for a resolved branch; miss+not-taken allocates nothing
   always_comb begin
      upd_hit_s  = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      entry_we_s = 1'b0;
      ctr_d      = ctr_q[upd_idx_s];
      target_d   = target_q[upd_idx_s];
      if (upd_valid) begin
         case ({upd_hit_s, upd_taken})
            2'b11: begin
               entry_we_s = 1'b1;
               target_d   = upd_target;
               if (ctr_q[upd_idx_s] == 2'd3) begin
                  ctr_d = 2'd3;
               end else begin
                  ctr_d = ctr_q[upd_idx_s] + 2'd1;
               end
            end
            2'b10: begin
               entry_we_s = 1'b1;
               if (ctr_q[upd_idx_s] == 2'd0) begin
                  ctr_d = 2'd0;
               end else begin
                  ctr_d = ctr_q[upd_idx_s] - 2'd1;
               end
            end
            2'b01: begin
               entry_we_s = 1'b1;
               target_d   = upd_target;
               ctr_d      = 2'd2;
            end
            2'b00:   entry_we_s = 1'b0;
            default: entry_we_s = 1'b0;
         endcase
      end else begin
         entry_we_s = 1'b0;
      end
   end

   // Entry array state: async clear, flush beats any concurrent update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= {TAG_W{1'b0}};
            target_q[i] <= {XLEN{1'b0}};
            ctr_q[i]    <= 2'd1;
         end
      end else if (flush_all) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'd1;
         end
      end else if (entry_we_s) begin
         valid_q[upd_idx_s]  <= 1'b1;
         tag_q[upd_idx_s]    <= upd_tag_s;
         target_q[upd_idx_s] <= target_d;
         ctr_q[upd_idx_s]    <= ctr_d;
      end
   end

   // Address bits outside index/tag do not take part in training
   logic unused_upd_pc_s;
   if (TAG_HI + 1 < XLEN) begin : g_unused_hi
      assign unused_upd_pc_s = ^{upd_pc[1:0], upd_pc[XLEN-1:TAG_HI+1]};
   end else begin : g_unused_lo
      assign unused_upd_pc_s = ^upd_pc[1:0];
   end

`ifdef BP_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   logic [CNT_W-1:0] perf_branches_q;
   logic [CNT_W-1:0] perf_mispredicts_q;

   // Count accepted updates and direction mispredicts; flush never clears these
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_branches_q    <= {CNT_W{1'b0}};
         perf_mispredicts_q <= {CNT_W{1'b0}};
      end else if (upd_valid && !flush_all) begin
         perf_branches_q <= perf_branches_q + CNT_ONE;
         if (upd_taken != upd_pred_taken) begin
            perf_mispredicts_q <= perf_mispredicts_q + CNT_ONE;
         end
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;
`else
   // Carried prediction is only consumed by the perf counters
   logic [CNT_W-1:0] unused_perf_s;
   assign unused_perf_s = {{(CNT_W-1){1'b0}}, upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (ENTRIES=16, TAG_W=8).
module tb_branch_predictor_btb;

   logic        clk;
   logic        reset_n;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        flush_all;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
`ifdef BP_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
   int          exp_br;
   int          exp_mis;
`endif

   int checks;
   int errors;

   branch_predictor_btb #(
      .XLEN(32), .ENTRIES(16), .TAG_W(8), .CNT_W(32)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_pc       (fetch_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .flush_all      (flush_all),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_pred_taken (upd_pred_taken)
`ifdef BP_PERF_CNT_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] pc,
                            input logic exp_taken, input logic [31:0] exp_target);
      fetch_pc = pc;
      #1;
      check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
      check({tag, "_target"}, pred_target, exp_target);
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic ptaken);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = taken;
      upd_target     = tgt;
      upd_pred_taken = ptaken;
   endtask

   task automatic edge_step();
      @(posedge clk);
`ifdef BP_PERF_CNT_EN
      if (upd_valid && !flush_all) begin
         exp_br++;
         if (upd_taken != upd_pred_taken) exp_mis++;
      end
`endif
      #1;
      upd_valid = 1'b0;
      flush_all = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
`ifdef BP_PERF_CNT_EN
      exp_br  = 0;
      exp_mis = 0;
`endif
      reset_n        = 1'b0;
      fetch_pc       = 32'h0;
      flush_all      = 1'b0;
      upd_valid      = 1'b0;
      upd_pc         = 32'h0;
      upd_taken      = 1'b0;
      upd_target     = 32'h0;
      upd_pred_taken = 1'b0;

      // Reset state and pc+4 wrap
      chk_fetch("rst_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
      chk_fetch("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
      #1 reset_n = 1'b1;
      edge_step();

      // Allocate on taken miss; same cycle still sees old contents
      set_upd(32'h100, 1'b1, 32'h40, 1'b0);
      chk_fetch("alloc_pre", 32'h100, 1'b0, 32'h104);
      edge_step();
      chk_fetch("alloc_post", 32'h100, 1'b1, 32'h40);

      // Counter 2->3->3->2->1->0 then back up 1->2
      set_upd(32'h100, 1'b1, 32'h40, 1'b1); edge_step();
      set_upd(32'h100, 1'b1, 32'h40, 1'b1); edge_step();
      set_upd(32'h100, 1'b0, 32'h999, 1'b1); edge_step();
      chk_fetch("ctr2_keep_tgt", 32'h100, 1'b1, 32'h40);
      set_upd(32'h100, 1'b0, 32'h0, 1'b1); edge_step();
      chk_fetch("ctr1", 32'h100, 1'b0, 32'h104);
      set_upd(32'h100, 1'b0, 32'h0, 1'b0); edge_step();
      chk_fetch("ctr0", 32'h100, 1'b0, 32'h104);
      set_upd(32'h100, 1'b1, 32'h80, 1'b0); edge_step();
      chk_fetch("ctr0_up1", 32'h100, 1'b0, 32'h104);
      set_upd(32'h100, 1'b1, 32'h80, 1'b0); edge_step();
      chk_fetch("ctr2_new_tgt", 32'h100, 1'b1, 32'h80);
      chk_fetch("low_bits_ignored", 32'h103, 1'b1, 32'h80);

      // Alias with different tag replaces the entry
      set_upd(32'h140, 1'b1, 32'h200, 1'b0); edge_step();
      chk_fetch("alias_old_miss", 32'h100, 1'b0, 32'h104);
      chk_fetch("alias_new_hit", 32'h140, 1'b1, 32'h200);
      chk_fetch("high_bits_ignored", 32'h4140, 1'b1, 32'h200);

      // Not-taken misses leave state alone and never allocate
      set_upd(32'h100, 1'b0, 32'h0, 1'b1); edge_step();
      chk_fetch("nt_miss_keep", 32'h140, 1'b1, 32'h200);
      set_upd(32'h204, 1'b0, 32'h700, 1'b0); edge_step();
      chk_fetch("nt_miss_noalloc", 32'h204, 1'b0, 32'h208);

      // Read during write on the same index
      set_upd(32'h140, 1'b1, 32'h300, 1'b1);
      chk_fetch("rdw_pre", 32'h140, 1'b1, 32'h200);
      edge_step();
      chk_fetch("rdw_post", 32'h140, 1'b1, 32'h300);

      // Flush wins over a concurrent update
      flush_all = 1'b1;
      set_upd(32'h208, 1'b1, 32'h500, 1'b1);
      edge_step();
      chk_fetch("flush_inval", 32'h140, 1'b0, 32'h144);
      chk_fetch("flush_drop", 32'h208, 1'b0, 32'h20C);

      // Fresh allocation after flush
      set_upd(32'h208, 1'b1, 32'h600, 1'b0); edge_step();
      chk_fetch("realloc", 32'h208, 1'b1, 32'h600);

`ifdef BP_PERF_CNT_EN
      check("perf_branches", perf_branches, exp_br);
      check("perf_mispredicts", perf_mispredicts, exp_mis);
`endif

      // Asynchronous reset in the middle of a cycle
      reset_n = 1'b0;
      chk_fetch("async_rst", 32'h208, 1'b0, 32'h20C);
`ifdef BP_PERF_CNT_EN
      check("perf_br_rst", perf_branches, 32'h0);
      check("perf_mis_rst", perf_mispredicts, 32'h0);
`endif
      reset_n = 1'b1;
      edge_step();
      chk_fetch("after_rst", 32'h140, 1'b0, 32'h144);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
